// File: rtl/tlc_pkg.sv
// tlc_pkg -- shared definitions for the traffic light controller.
//   Phase encodings (3-bit, value 7 unused/illegal), lamp one-hot codes
//   {red,yellow,green}, and lamp decode helpers used by the top level.
package tlc_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5,
    PED  = 3'd6
  } phase_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // North-south lamp for a given phase; anything outside NS_G/NS_Y is red.
  function automatic logic [2:0] ns_lamp(input logic [PHASE_W-1:0] p);
    case (p)
      NS_G:    ns_lamp = LAMP_GRN;
      NS_Y:    ns_lamp = LAMP_YEL;
      default: ns_lamp = LAMP_RED;
    endcase
  endfunction

  // East-west lamp for a given phase; anything outside EW_G/EW_Y is red.
  function automatic logic [2:0] ew_lamp(input logic [PHASE_W-1:0] p);
    case (p)
      EW_G:    ew_lamp = LAMP_GRN;
      EW_Y:    ew_lamp = LAMP_YEL;
      default: ew_lamp = LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_register_3b.sv
// phase_register_3b -- 3-bit phase state register.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, loads AR2
//   d     : next phase (controller holds by feeding q back)
//   q     : current phase
import tlc_pkg::*;

module phase_register_3b (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] d,
  output logic [PHASE_W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= AR2;
    else       q <= d;
  end

endmodule

// File: rtl/traffic_light_controller.sv
// traffic_light_controller -- two-road intersection sequencer with a
// pedestrian walk phase.
//   clk, reset : clock, asynchronous active-high reset
//   enable     : 1 = run, 0 = freeze phase and timer (ped latch still runs)
//   ped_req    : pedestrian button, level-sampled
//   emergency  : (only with TLC_EMERGENCY_OVERRIDE_EN) drive roads to red
//   ped_ack    : one-cycle pulse when a pedestrian request is latched
//   ns_light   : north-south lamp, one-hot {red,yellow,green}
//   ew_light   : east-west lamp, one-hot {red,yellow,green}
//   walk       : pedestrian walk lamp
//   phase      : current phase encoding
// Optional feature macro: TLC_EMERGENCY_OVERRIDE_EN.
import tlc_pkg::*;

module traffic_light_controller #(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1,
  parameter int PED_CYCLES    = 4,
  parameter int TIMER_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               ped_req,
`ifdef TLC_EMERGENCY_OVERRIDE_EN
  input  logic               emergency,
`endif
  output logic               ped_ack,
  output logic [2:0]         ns_light,
  output logic [2:0]         ew_light,
  output logic               walk,
  output logic [PHASE_W-1:0] phase
);

  // Timer load values: a phase lasts (load + 1) enabled cycles.
  localparam logic [TIMER_W-1:0] LD_G  = TIMER_W'(GREEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LD_Y  = TIMER_W'(YELLOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LD_AR = TIMER_W'(ALLRED_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LD_P  = TIMER_W'(PED_CYCLES - 1);

  logic [PHASE_W-1:0] nxt_phase;
  logic [TIMER_W-1:0] timer, nxt_timer;
  logic               next_dir, nxt_dir;   // 0 = NS next, 1 = EW next
  logic               ped_pending;
  logic               hold_red;            // emergency parks red phases

`ifdef TLC_EMERGENCY_OVERRIDE_EN
  // Yellow phases are exempt so they complete their normal duration.
  assign hold_red = emergency && (phase != NS_Y) && (phase != EW_Y);
`else
  assign hold_red = 1'b0;
`endif

  phase_register_3b u_phase (
    .clk   (clk),
    .reset (reset),
    .d     (nxt_phase),
    .q     (phase)
  );

  always_comb begin
    nxt_phase = phase;
    nxt_timer = timer;
    nxt_dir   = next_dir;
    if (phase == 3'd7) begin
      // Illegal encoding: recover into a clearance phase regardless of enable.
      nxt_phase = AR1;
      nxt_timer = LD_AR;
    end else if (enable) begin
      if (hold_red) begin
        case (phase)
          NS_G:    begin nxt_phase = NS_Y; nxt_timer = LD_Y; end
          EW_G:    begin nxt_phase = EW_Y; nxt_timer = LD_Y; end
          PED:     begin nxt_phase = AR2;  nxt_timer = '0;   end
          default: nxt_timer = '0;
        endcase
      end else if (timer != '0) begin
        nxt_timer = timer - 1'b1;
      end else begin
        case (phase)
          NS_G: begin nxt_phase = NS_Y; nxt_timer = LD_Y;  end
          NS_Y: begin nxt_phase = AR1;  nxt_timer = LD_AR; end
          AR1: begin
            nxt_dir = 1'b1;
            if (ped_pending) begin nxt_phase = PED;  nxt_timer = LD_P; end
            else             begin nxt_phase = EW_G; nxt_timer = LD_G; end
          end
          EW_G: begin nxt_phase = EW_Y; nxt_timer = LD_Y;  end
          EW_Y: begin nxt_phase = AR2;  nxt_timer = LD_AR; end
          AR2: begin
            nxt_dir = 1'b0;
            if (ped_pending) begin nxt_phase = PED;  nxt_timer = LD_P; end
            else             begin nxt_phase = NS_G; nxt_timer = LD_G; end
          end
          PED: begin
            nxt_phase = next_dir ? EW_G : NS_G;
            nxt_timer = LD_G;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer       <= LD_AR;
      next_dir    <= 1'b0;
      ped_pending <= 1'b0;
      ped_ack     <= 1'b0;
    end else begin
      timer    <= nxt_timer;
      next_dir <= nxt_dir;
      ped_ack  <= 1'b0;
      // Latch looks at the current phase, so a press on the PED-entry edge
      // is still accepted only if it was not already pending.
      if (ped_req && !ped_pending && (phase != PED)) begin
        ped_pending <= 1'b1;
        ped_ack     <= 1'b1;
      end else if ((nxt_phase == PED) && (phase != PED)) begin
        ped_pending <= 1'b0;
      end
    end
  end

  assign ns_light = ns_lamp(phase);
  assign ew_light = ew_lamp(phase);
  assign walk     = (phase == PED);

endmodule
